// File: rtl/pa_mean_pkg.sv
// ============================================================================
// Module   : pa_mean_pkg
// Brief    : Shared state encoding and counter limits for the mean requester.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pa_mean_pkg;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned SIZE_CNT_DEF = 16;
    localparam logic [31:0] CNT_MAX      = (32'd1 << SIZE_CNT_DEF) - 32'd1;

    // Largest count a SIZE_CNT-bit counter may reach before a request is forced.
    function automatic logic [31:0] cnt_max_f(input int unsigned size_cnt);
        return (32'd1 << size_cnt) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pa_mean_sat_acc.sv
// ============================================================================
// Module   : pa_mean_sat_acc
// Brief    : Saturating sample accumulator with sample counter and sticky
//            overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pa_mean_sat_acc #(
    parameter int SIZE_DATA = 32,
    parameter int SIZE_CNT  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_add,
    input  logic [SIZE_DATA-1:0] i_data,
    output logic [SIZE_DATA-1:0] o_sum,
    output logic [SIZE_DATA-1:0] o_sum_next,
    output logic [SIZE_CNT-1:0]  o_count,
    output logic [SIZE_CNT-1:0]  o_count_next,
    output logic                 o_overflow
);

    logic [SIZE_DATA-1:0] r_sum;
    logic [SIZE_CNT-1:0]  r_count;
    logic                 r_overflow;

    logic [SIZE_DATA:0]   w_add;
    logic [SIZE_DATA-1:0] w_sum_sat;
    logic [SIZE_CNT-1:0]  w_count_inc;
    logic                 w_overflow_next;

    // A carry out of the adder pins the sum at all-ones for the rest of the set.
    always_comb begin
        w_add           = {1'b0, r_sum} + {1'b0, i_data};
        w_sum_sat       = w_add[SIZE_DATA] ? {SIZE_DATA{1'b1}} : w_add[SIZE_DATA-1:0];
        w_count_inc     = r_count + SIZE_CNT'(1);
        w_overflow_next = r_overflow | w_add[SIZE_DATA];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_sum      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_add) begin
            r_sum      <= w_sum_sat;
            r_count    <= w_count_inc;
            r_overflow <= w_overflow_next;
        end
    end

    assign o_sum        = r_sum;
    assign o_sum_next   = w_sum_sat;
    assign o_count      = r_count;
    assign o_count_next = w_count_inc;
    assign o_overflow   = r_overflow;

endmodule

`default_nettype wire

// File: rtl/pa_mean_requester.sv
// ============================================================================
// Module   : pa_mean_requester
// Brief    : Accumulates a sample set, requests sum/count from a sequential
//            divider and presents the mean. Macro PA_MEAN_ROUND_EN selects
//            round-to-nearest instead of truncation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pa_mean_requester
    import pa_mean_pkg::*;
#(
    parameter int SIZE_DATA = 32,
    parameter int SIZE_CNT  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_valid,
    input  logic [SIZE_DATA-1:0] i_data,
    input  logic                 i_last,
    output logic                 o_ready,
    output logic                 o_div_start,
    output logic [SIZE_DATA-1:0] o_div_dividend,
    output logic [SIZE_DATA-1:0] o_div_divisor,
    input  logic [SIZE_DATA-1:0] i_div_quotient,
    input  logic [SIZE_DATA-1:0] i_div_remainder,
    input  logic                 i_div_done,
    output logic [SIZE_DATA-1:0] o_mean,
    output logic                 o_mean_valid,
    output logic                 o_overflow,
    output logic                 o_busy
);

    localparam logic [SIZE_CNT-1:0] c_CNT_MAX = SIZE_CNT'(cnt_max_f(SIZE_CNT));

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_discard;
    logic                 w_discard_next;
    logic [SIZE_DATA-1:0] r_dividend;
    logic [SIZE_DATA-1:0] r_divisor;
    logic [SIZE_DATA-1:0] r_mean;

    logic                 w_accept;
    logic                 w_to_req;
    logic                 w_acc_clear;
    logic                 w_mean_load;
    logic [SIZE_DATA-1:0] w_mean_res;

    logic [SIZE_DATA-1:0] w_sum;
    logic [SIZE_DATA-1:0] w_sum_next;
    logic [SIZE_CNT-1:0]  w_count;
    logic [SIZE_CNT-1:0]  w_count_next;
    logic                 w_overflow;

    pa_mean_sat_acc #(
        .SIZE_DATA (SIZE_DATA),
        .SIZE_CNT  (SIZE_CNT)
    ) u_sat_acc (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_acc_clear),
        .i_add        (w_accept),
        .i_data       (i_data),
        .o_sum        (w_sum),
        .o_sum_next   (w_sum_next),
        .o_count      (w_count),
        .o_count_next (w_count_next),
        .o_overflow   (w_overflow)
    );

    // Clear beats a simultaneous sample: the sample is dropped, not accumulated.
    assign w_accept = (r_state == ACC) && i_valid && !i_clear;
    assign w_to_req = w_accept && (i_last || (w_count_next == c_CNT_MAX));

`ifdef PA_MEAN_ROUND_EN
    logic [SIZE_DATA:0] w_rem2;
    logic               w_round_up;

    always_comb begin
        w_rem2     = {i_div_remainder, 1'b0};
        w_round_up = (w_rem2 >= {1'b0, r_divisor}) && (i_div_quotient != {SIZE_DATA{1'b1}});
        w_mean_res = i_div_quotient + SIZE_DATA'(w_round_up);
    end
`else
    logic w_unused_rem;

    assign w_unused_rem = ^i_div_remainder;
    assign w_mean_res   = i_div_quotient;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_discard_next = r_discard;
        w_acc_clear    = 1'b0;
        w_mean_load    = 1'b0;
        case (r_state)
            ACC: begin
                if (i_clear) begin
                    w_acc_clear = 1'b1;
                end else if (w_to_req) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (i_clear) begin
                    w_acc_clear  = 1'b1;
                    w_state_next = ACC;
                end else begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                // A clear here must not restart the busy divider; wait it out.
                if (i_clear) begin
                    w_discard_next = 1'b1;
                end
                if (i_div_done) begin
                    w_discard_next = 1'b0;
                    if (r_discard || i_clear) begin
                        w_acc_clear  = 1'b1;
                        w_state_next = ACC;
                    end else begin
                        w_mean_load  = 1'b1;
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                w_acc_clear  = 1'b1;
                w_state_next = ACC;
            end
            default: begin
                w_acc_clear  = 1'b1;
                w_state_next = ACC;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ACC;
            r_discard  <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_mean     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_discard <= w_discard_next;
            if (w_to_req) begin
                r_dividend <= w_sum_next;
                r_divisor  <= SIZE_DATA'(w_count_next);
            end
            if (w_mean_load) begin
                r_mean <= w_mean_res;
            end
        end
    end

    logic w_unused_acc;
    assign w_unused_acc = ^{w_sum, w_count};

    assign o_ready        = (r_state == ACC);
    assign o_busy         = (r_state != ACC);
    assign o_div_start    = (r_state == REQ);
    assign o_mean_valid   = (r_state == DONE);
    assign o_div_dividend = r_dividend;
    assign o_div_divisor  = r_divisor;
    assign o_mean         = r_mean;
    assign o_overflow     = w_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pa_mean_requester.sv
// ============================================================================
// Module   : tb_pa_mean_requester
// Brief    : Directed self-checking bench; a 32/16 instance for the main flow
//            and an 8/3 instance for saturation and forced-request cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pa_mean_requester;

`ifdef PA_MEAN_ROUND_EN
    localparam logic [31:0] EXP_MEAN_56  = 32'd6;
    localparam logic [7:0]  EXP_MEAN_SAT = 8'd128;
`else
    localparam logic [31:0] EXP_MEAN_56  = 32'd5;
    localparam logic [7:0]  EXP_MEAN_SAT = 8'd127;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: SIZE_DATA = 32, SIZE_CNT = 16
    logic        rst_n_a, clear_a, valid_a, last_a, done_a;
    logic [31:0] data_a, q_a, r_a;
    logic        ready_a, start_a, mvalid_a, ovf_a, busy_a;
    logic [31:0] dividend_a, divisor_a, mean_a;

    // Instance B: SIZE_DATA = 8, SIZE_CNT = 3
    logic        rst_n_b, clear_b, valid_b, last_b, done_b;
    logic [7:0]  data_b, q_b, r_b;
    logic        ready_b, start_b, mvalid_b, ovf_b, busy_b;
    logic [7:0]  dividend_b, divisor_b, mean_b;

    int n_cmp = 0;
    int n_err = 0;

    pa_mean_requester #(.SIZE_DATA(32), .SIZE_CNT(16)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n_a), .i_clear(clear_a), .i_valid(valid_a),
        .i_data(data_a), .i_last(last_a), .o_ready(ready_a), .o_div_start(start_a),
        .o_div_dividend(dividend_a), .o_div_divisor(divisor_a),
        .i_div_quotient(q_a), .i_div_remainder(r_a), .i_div_done(done_a),
        .o_mean(mean_a), .o_mean_valid(mvalid_a), .o_overflow(ovf_a), .o_busy(busy_a)
    );

    pa_mean_requester #(.SIZE_DATA(8), .SIZE_CNT(3)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n_b), .i_clear(clear_b), .i_valid(valid_b),
        .i_data(data_b), .i_last(last_b), .o_ready(ready_b), .o_div_start(start_b),
        .o_div_dividend(dividend_b), .o_div_divisor(divisor_b),
        .i_div_quotient(q_b), .i_div_remainder(r_b), .i_div_done(done_b),
        .o_mean(mean_b), .o_mean_valid(mvalid_b), .o_overflow(ovf_b), .o_busy(busy_b)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] d, input logic l);
        valid_a = 1'b1; data_a = d; last_a = l;
        step();
        valid_a = 1'b0; last_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic l);
        valid_b = 1'b1; data_b = d; last_b = l;
        step();
        valid_b = 1'b0; last_b = 1'b0;
    endtask

    initial begin
        rst_n_a = 1'b0; clear_a = 1'b0; valid_a = 1'b0; last_a = 1'b0; done_a = 1'b0;
        data_a = '0; q_a = '0; r_a = '0;
        rst_n_b = 1'b0; clear_b = 1'b0; valid_b = 1'b0; last_b = 1'b0; done_b = 1'b0;
        data_b = '0; q_b = '0; r_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_start", start_a, 0);
        check_val("rst_dividend", dividend_a, 0);
        check_val("rst_divisor", divisor_a, 0);
        check_val("rst_mean", mean_a, 0);
        check_val("rst_mvalid", mvalid_a, 0);
        check_val("rst_ovf", ovf_a, 0);
        check_val("rst_busy", busy_a, 0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        step();
        check_val("rel_ready", ready_a, 1);

        // 10+20+30+41 = 101 over 4 samples; 101/4 = 25 r1 rounds to 25 either way
        send_a(32'd10, 1'b0); send_a(32'd20, 1'b0); send_a(32'd30, 1'b0);
        check_val("acc_ready", ready_a, 1);
        send_a(32'd41, 1'b1);
        check_val("t1_start", start_a, 1);
        check_val("t1_dividend", dividend_a, 101);
        check_val("t1_divisor", divisor_a, 4);
        check_val("t1_ready_req", ready_a, 0);
        step();
        check_val("t1_start_wait", start_a, 0);
        check_val("t1_busy_wait", busy_a, 1);
        step();
        done_a = 1'b1; q_a = 32'd25; r_a = 32'd1;
        step();
        done_a = 1'b0;
        check_val("t1_mvalid", mvalid_a, 1);
        check_val("t1_mean", mean_a, 25);
        check_val("t1_ready_done", ready_a, 0);
        step();
        check_val("t1_mvalid_end", mvalid_a, 0);
        check_val("t1_ready_acc", ready_a, 1);

        // 11/2 = 5 r1: rounding gives 6, truncation 5
        send_a(32'd5, 1'b0); send_a(32'd6, 1'b1);
        check_val("t2_dividend", dividend_a, 11);
        check_val("t2_divisor", divisor_a, 2);
        step();
        done_a = 1'b1; q_a = 32'd5; r_a = 32'd1;
        step();
        done_a = 1'b0;
        check_val("t2_mean", mean_a, EXP_MEAN_56);
        check_val("t2_mvalid", mvalid_a, 1);
        step();

        // Clear with a valid sample in ACC drops that sample
        valid_a = 1'b1; data_a = 32'd1000; clear_a = 1'b1;
        step();
        valid_a = 1'b0; clear_a = 1'b0;
        send_a(32'd4, 1'b1);
        check_val("clr_acc_dividend", dividend_a, 4);
        check_val("clr_acc_divisor", divisor_a, 1);
        step();

        // Clear in WAIT: result discarded, no restart of the divider
        clear_a = 1'b1;
        step();
        clear_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("clrw_start", start_a, 0);
            check_val("clrw_busy", busy_a, 1);
            step();
        end
        done_a = 1'b1; q_a = 32'd99; r_a = 32'd0;
        step();
        done_a = 1'b0;
        check_val("clrw_mvalid", mvalid_a, 0);
        check_val("clrw_mean_held", mean_a, EXP_MEAN_56);
        check_val("clrw_ready", ready_a, 1);
        step();
        check_val("clrw_mvalid2", mvalid_a, 0);
        check_val("clrw_start2", start_a, 0);

        // Asynchronous reset while waiting on the divider
        send_a(32'd3, 1'b1);
        step();
        check_val("rstw_busy_pre", busy_a, 1);
        #2 rst_n_a = 1'b0;
        #1;
        check_val("rstw_busy", busy_a, 0);
        check_val("rstw_mean", mean_a, 0);
        check_val("rstw_dividend", dividend_a, 0);
        check_val("rstw_divisor", divisor_a, 0);
        check_val("rstw_start", start_a, 0);
        #2 rst_n_a = 1'b1;
        step();
        check_val("rstw_ready", ready_a, 1);
        send_a(32'd8, 1'b0); send_a(32'd8, 1'b1);
        check_val("rstw_new_dividend", dividend_a, 16);
        check_val("rstw_new_divisor", divisor_a, 2);
        step();
        done_a = 1'b1; q_a = 32'd8; r_a = 32'd0;
        step();
        done_a = 1'b0;
        check_val("rstw_new_mean", mean_a, 8);
        check_val("rstw_new_mvalid", mvalid_a, 1);
        step();

        // 8-bit saturation: 200 + 100 pins at 255
        send_b(8'd200, 1'b0);
        check_val("sat_ovf_pre", ovf_b, 0);
        send_b(8'd100, 1'b1);
        check_val("sat_ovf", ovf_b, 1);
        check_val("sat_dividend", dividend_b, 255);
        check_val("sat_divisor", divisor_b, 2);
        step();
        check_val("sat_ovf_wait", ovf_b, 1);
        done_b = 1'b1; q_b = 8'd127; r_b = 8'd1;
        step();
        done_b = 1'b0;
        check_val("sat_mean", mean_b, EXP_MEAN_SAT);
        check_val("sat_ovf_done", ovf_b, 1);
        step();
        check_val("sat_ovf_clr", ovf_b, 0);

        // 3-bit counter: the 7th sample forces the request
        for (int i = 1; i <= 7; i++) begin
            send_b(8'(i), 1'b0);
        end
        check_val("cnt_start", start_b, 1);
        check_val("cnt_divisor", divisor_b, 7);
        check_val("cnt_dividend", dividend_b, 28);
        step();
        valid_b = 1'b1; data_b = 8'd50; last_b = 1'b1;
        check_val("cnt_ready_wait", ready_b, 0);
        step();
        check_val("cnt_dividend_held", dividend_b, 28);
        check_val("cnt_divisor_held", divisor_b, 7);
        done_b = 1'b1; q_b = 8'd4; r_b = 8'd0;
        step();
        done_b = 1'b0;
        check_val("cnt_mean", mean_b, 4);
        check_val("cnt_mvalid", mvalid_b, 1);
        step();
        check_val("cnt_ready_acc", ready_b, 1);
        step();
        valid_b = 1'b0; last_b = 1'b0;
        check_val("held_start", start_b, 1);
        check_val("held_dividend", dividend_b, 50);
        check_val("held_divisor", divisor_b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
